// File: rtl/rstctl_if.sv
// CSR bus bundle between the bus master and the reset controller.
// Latency: wires only; read data is registered inside the slave.
// Backpressure: none, every access completes in one cycle.
interface rstctl_if;
  logic [13:0] csr_a;
  logic        csr_we;
  logic [31:0] csr_di;
  logic [31:0] csr_do;

  modport master (output csr_a, output csr_we, output csr_di, input csr_do);
  modport slave  (input csr_a, input csr_we, input csr_di, output csr_do);
endinterface

// File: rtl/rstctl.sv
// Reset controller: sync/debounce sources, sw/watchdog triggers, staggered release, cause log.
// Latency: source->rst_out high 3 cycles; CSR write->reset 1 cycle; CSR read data 1 cycle.
// Backpressure: none; watchdog built only when RSTCTL_WDT_EN is defined.
module rstctl #(
  parameter logic [3:0] csr_addr   = 4'h2,
  parameter int         nsources   = 2,
  parameter int         nchannels  = 3,
  parameter int         debounce_w = 20,
  parameter int         stagger    = 16
) (
  input  logic                 sys_clk,
  input  logic                 sys_rst,
  input  logic [nsources-1:0]  rst_src,
  rstctl_if.slave              csr,
  output logic [nchannels-1:0] rst_out
);

  // Timer counts stagger-1 down to 0, so a release lands exactly stagger cycles apart.
  localparam int                 TW       = (stagger > 1) ? $clog2(stagger) : 1;
  localparam logic [TW-1:0]      TMR_LOAD = TW'(stagger - 1);
  // Channel 0 (CPU/bus) can never be held by software.
  localparam logic [nchannels-1:0] MASK_OK = ~nchannels'(1);

  typedef enum logic [1:0] {S_HOLD, S_RELEASE, S_RUN} state_t;

  logic [nsources-1:0]   r_sync1, r_sync2;
  logic [debounce_w-1:0] r_db_cnt;
  state_t                r_state, w_state_nxt;
  logic [nchannels-1:0]  r_fsm_hold, w_hold_nxt;
  logic [TW-1:0]         r_tmr, w_tmr_nxt;
  logic [nchannels-1:0]  r_hold_mask;
  logic [nsources-1:0]   r_cause_src;
  logic                  r_cause_sw, r_cause_por;
  logic [31:0]           r_csr_do, w_rd;

  logic        w_any_src, w_ext_trig, w_sw_trig, w_wdt_trig, w_trig;
  logic        w_sel, w_wr, w_wr_cause, w_wr_ctrl, w_wr_rld, w_wr_cnt;
  logic [2:0]  w_reg;
  logic        w_wdt_en, w_cause_wdt;
  logic [31:0] w_wdt_reload, w_wdt_cnt;
  logic        w_unused;

  // CSR decode; only the bank nibble and the low register index take part.
  assign w_sel      = (csr.csr_a[13:10] == csr_addr);
  assign w_wr       = w_sel & csr.csr_we;
  assign w_reg      = csr.csr_a[2:0];
  assign w_wr_cause = w_wr & (w_reg == 3'd0);
  assign w_wr_ctrl  = w_wr & (w_reg == 3'd1);
  assign w_wr_rld   = w_wr & (w_reg == 3'd2);
  assign w_wr_cnt   = w_wr & (w_reg == 3'd3);
  assign w_sw_trig  = w_wr_ctrl & csr.csr_di[0];
  assign w_unused   = ^{csr.csr_a[9:3], csr.csr_di};

  assign w_any_src  = |r_sync2;
  assign w_ext_trig = w_any_src | (r_db_cnt != '0);
  assign w_trig     = w_ext_trig | w_sw_trig | w_wdt_trig;

  // Two-flop synchroniser per asynchronous source.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= rst_src;
      r_sync2 <= r_sync1;
    end
  end

  // Debounce: reload on any live source or internal trigger, otherwise drain to 0.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      r_db_cnt <= '1;
    end else if (w_any_src | w_sw_trig | w_wdt_trig) begin
      r_db_cnt <= '1;
    end else if (r_db_cnt != '0) begin
      r_db_cnt <= r_db_cnt - 1'b1;
    end
  end

  // FSM state, per-channel hold bits and stagger timer.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      r_state    <= S_HOLD;
      r_fsm_hold <= '1;
      r_tmr      <= TMR_LOAD;
    end else begin
      r_state    <= w_state_nxt;
      r_fsm_hold <= w_hold_nxt;
      r_tmr      <= w_tmr_nxt;
    end
  end

  // Next state: any trigger wins; otherwise release channels low index first.
  always_comb begin
    w_state_nxt = r_state;
    w_hold_nxt  = r_fsm_hold;
    w_tmr_nxt   = r_tmr;
    if (w_trig) begin
      w_state_nxt = S_HOLD;
      w_hold_nxt  = '1;
      w_tmr_nxt   = TMR_LOAD;
    end else begin
      case (r_state)
        S_HOLD: begin
          w_state_nxt = S_RELEASE;
          w_tmr_nxt   = TMR_LOAD;
        end
        S_RELEASE: begin
          if (r_tmr == '0) begin
            w_hold_nxt = r_fsm_hold << 1;
            w_tmr_nxt  = TMR_LOAD;
            if (w_hold_nxt == '0) w_state_nxt = S_RUN;
          end else begin
            w_tmr_nxt = r_tmr - 1'b1;
          end
        end
        S_RUN: begin
          w_hold_nxt = '0;
        end
        default: begin
          w_state_nxt = S_HOLD;
          w_hold_nxt  = '1;
        end
      endcase
    end
  end

  assign rst_out = r_fsm_hold | (r_hold_mask & MASK_OK);

  // Sticky cause bits, write-1-to-clear, a same-cycle set beats the clear.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      r_cause_src <= '0;
      r_cause_sw  <= 1'b0;
      r_cause_por <= 1'b1;
    end else begin
      r_cause_src <= (r_cause_src & ~(w_wr_cause ? csr.csr_di[nsources-1:0] : '0)) | r_sync2;
      r_cause_sw  <= (r_cause_sw & ~(w_wr_cause & csr.csr_di[17])) | w_sw_trig;
      r_cause_por <= r_cause_por & ~(w_wr_cause & csr.csr_di[18]);
    end
  end

  // Hold mask lives in CTRL and survives triggered resets.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      r_hold_mask <= '0;
    end else if (w_wr_ctrl) begin
      r_hold_mask <= csr.csr_di[8 +: nchannels];
    end
  end

`ifdef RSTCTL_WDT_EN
  logic        r_wdt_en, r_cause_wdt;
  logic [31:0] r_wdt_reload, r_wdt_cnt;

  // Expiry only counts in RUN; a zero count with enable set fires at once.
  assign w_wdt_trig = (r_state == S_RUN) && r_wdt_en && (r_wdt_cnt == 32'd0);

  // Watchdog registers: reload on enable rising or kick, decrement in RUN.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      r_wdt_en     <= 1'b0;
      r_wdt_reload <= '0;
      r_wdt_cnt    <= '0;
      r_cause_wdt  <= 1'b0;
    end else begin
      if (w_wr_rld) r_wdt_reload <= csr.csr_di;
      if (w_wr_ctrl) r_wdt_en <= csr.csr_di[1];
      if (w_wdt_trig) r_wdt_en <= 1'b0;
      if (w_wr_cnt || (w_wr_ctrl && csr.csr_di[1] && !r_wdt_en)) begin
        r_wdt_cnt <= r_wdt_reload;
      end else if ((r_state == S_RUN) && r_wdt_en && (r_wdt_cnt != 32'd0)) begin
        r_wdt_cnt <= r_wdt_cnt - 32'd1;
      end
      r_cause_wdt <= (r_cause_wdt & ~(w_wr_cause & csr.csr_di[16])) | w_wdt_trig;
    end
  end

  assign w_wdt_en     = r_wdt_en;
  assign w_cause_wdt  = r_cause_wdt;
  assign w_wdt_reload = r_wdt_reload;
  assign w_wdt_cnt    = r_wdt_cnt;
`else
  assign w_wdt_trig   = 1'b0;
  assign w_wdt_en     = 1'b0;
  assign w_cause_wdt  = 1'b0;
  assign w_wdt_reload = '0;
  assign w_wdt_cnt    = '0;
`endif

  // Read mux over the current register contents.
  always_comb begin
    w_rd = '0;
    case (w_reg)
      3'd0: begin
        w_rd[nsources-1:0] = r_cause_src;
        w_rd[16]           = w_cause_wdt;
        w_rd[17]           = r_cause_sw;
        w_rd[18]           = r_cause_por;
      end
      3'd1: begin
        w_rd[1]             = w_wdt_en;
        w_rd[8 +: nchannels] = r_hold_mask;
      end
      3'd2: w_rd = w_wdt_reload;
      3'd3: w_rd = w_wdt_cnt;
      default: w_rd = '0;
    endcase
  end

  // Registered read data, zero when another bank is addressed.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      r_csr_do <= '0;
    end else begin
      r_csr_do <= w_sel ? w_rd : 32'd0;
    end
  end

  assign csr.csr_do = r_csr_do;

endmodule

// File: tb/tb_rstctl.sv
// Directed bench for rstctl: power-on, glitchy source, sw reset, hold mask, CSR bus.
// Latency expectations are hand-derived for debounce_w=4, stagger=4, nchannels=3.
// Watchdog steps run only when RSTCTL_WDT_EN is defined; otherwise its absence is checked.
module tb_rstctl;
  logic        sys_clk = 1'b0;
  logic        sys_rst;
  logic [1:0]  rst_src;
  logic [2:0]  rst_out;
  logic [31:0] rd;
  int          n;
  int          n_assert = 0;
  int          n_fail   = 0;

  rstctl_if bus ();

  rstctl #(
    .csr_addr  (4'h2),
    .nsources  (2),
    .nchannels (3),
    .debounce_w(4),
    .stagger   (4)
  ) dut (
    .sys_clk(sys_clk),
    .sys_rst(sys_rst),
    .rst_src(rst_src),
    .csr    (bus),
    .rst_out(rst_out)
  );

  always #5 sys_clk = ~sys_clk;

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic csr_wr(input logic [3:0] bank, input logic [2:0] a, input logic [31:0] d);
    bus.csr_a  = {bank, 7'd0, a};
    bus.csr_we = 1'b1;
    bus.csr_di = d;
    tick();
    bus.csr_we = 1'b0;
    bus.csr_di = '0;
  endtask

  task automatic csr_rd(input logic [3:0] bank, input logic [2:0] a, output logic [31:0] d);
    bus.csr_a = {bank, 7'd0, a};
    tick();
    d = bus.csr_do;
  endtask

  // Cycles until rst_out shows the wanted pattern, capped at 200.
  task automatic wait_out(input logic [2:0] exp, output int cnt);
    cnt = 0;
    while (rst_out !== exp && cnt < 200) begin
      tick();
      cnt++;
    end
  endtask

  initial begin
    sys_rst    = 1'b1;
    rst_src    = 2'b00;
    bus.csr_a  = {4'h2, 7'd0, 3'd0};
    bus.csr_we = 1'b0;
    bus.csr_di = '0;
    repeat (3) tick();
    chk("reset_rst_out", {29'd0, rst_out}, 32'h7);
    chk("reset_csr_do", bus.csr_do, 32'h0);

    // Power-on: 15 hold cycles, 1 to enter RELEASE, then falls 4 apart.
    sys_rst = 1'b0;
    wait_out(3'b110, n); chk("por_ch0_fall", n, 20);
    wait_out(3'b100, n); chk("por_ch1_fall", n, 4);
    wait_out(3'b000, n); chk("por_ch2_fall", n, 4);
    csr_rd(4'h2, 3'd0, rd); chk("por_cause", rd, 32'h40000);
    csr_rd(4'h3, 3'd0, rd); chk("other_bank_reads_0", rd, 32'h0);
    csr_wr(4'h2, 3'd5, 32'hffff_ffff);
    csr_rd(4'h2, 3'd5, rd); chk("unmapped_reads_0", rd, 32'h0);
    csr_rd(4'h2, 3'd0, rd); chk("unmapped_wr_ignored", rd, 32'h40000);

    // Glitchy source 1: 3 cycles to assert, held high through the burst.
    rst_src = 2'b10;
    tick(); tick();
    chk("src_lat_2cyc", {29'd0, rst_out}, 32'h0);
    tick();
    chk("src_lat_3cyc", {29'd0, rst_out}, 32'h7);
    rst_src = 2'b00; tick(); chk("glitch_hold_a", {29'd0, rst_out}, 32'h7);
    rst_src = 2'b10; tick(); chk("glitch_hold_b", {29'd0, rst_out}, 32'h7);
    rst_src = 2'b00; tick(); chk("glitch_hold_c", {29'd0, rst_out}, 32'h7);
    rst_src = 2'b10; tick(); chk("glitch_hold_d", {29'd0, rst_out}, 32'h7);
    rst_src = 2'b00; tick(); chk("glitch_hold_e", {29'd0, rst_out}, 32'h7);
    // 2 sync + 16 debounce/entry + 4 stagger = 22 from the final low, 1 already spent.
    wait_out(3'b110, n); chk("src_release_ch0", n, 21);
    wait_out(3'b100, n); chk("src_release_ch1", n, 4);
    wait_out(3'b000, n); chk("src_release_ch2", n, 4);
    csr_rd(4'h2, 3'd0, rd); chk("cause_src1", rd, 32'h40002);
    csr_wr(4'h2, 3'd0, 32'h2);
    csr_rd(4'h2, 3'd0, rd); chk("cause_src1_w1c", rd, 32'h40000);

    // Software reset, then again in the middle of the release sequence.
    csr_wr(4'h2, 3'd1, 32'h1);
    chk("sw_rst_next_cycle", {29'd0, rst_out}, 32'h7);
    wait_out(3'b110, n); chk("sw_release_ch0", n, 20);
    csr_wr(4'h2, 3'd1, 32'h1);
    chk("sw_rst_in_release", {29'd0, rst_out}, 32'h7);
    wait_out(3'b110, n); chk("sw_restart_ch0", n, 20);
    wait_out(3'b100, n); chk("sw_restart_ch1", n, 4);
    wait_out(3'b000, n); chk("sw_restart_ch2", n, 4);
    csr_rd(4'h2, 3'd0, rd); chk("cause_sw", rd, 32'h60000);
    csr_rd(4'h2, 3'd1, rd); chk("ctrl_bit0_reads_0", rd, 32'h0);

    // Hold mask: channels 2:1 held, channel 0 cannot be held.
    csr_wr(4'h2, 3'd1, 32'h700);
    chk("mask_applied", {29'd0, rst_out}, 32'h6);
    repeat (5) tick();
    chk("mask_stays", {29'd0, rst_out}, 32'h6);
    csr_rd(4'h2, 3'd1, rd); chk("ctrl_mask_read", rd, 32'h700);
    csr_wr(4'h2, 3'd1, 32'h0);
    chk("mask_cleared", {29'd0, rst_out}, 32'h0);

    // Clearing a cause bit while its source is still asserted: set wins.
    rst_src = 2'b01;
    repeat (4) tick();
    csr_wr(4'h2, 3'd0, 32'h1);
    csr_rd(4'h2, 3'd0, rd); chk("set_beats_clear", rd, 32'h60001);
    rst_src = 2'b00;
    wait_out(3'b000, n); chk("src0_recover", n, 30);
    csr_wr(4'h2, 3'd0, 32'h1);
    csr_rd(4'h2, 3'd0, rd); chk("cause_src0_w1c", rd, 32'h60000);

`ifdef RSTCTL_WDT_EN
    // Watchdog: reload 20, no kick; expires after counting 20 down in RUN.
    csr_wr(4'h2, 3'd2, 32'd20);
    csr_rd(4'h2, 3'd2, rd); chk("wdt_reload_read", rd, 32'd20);
    csr_wr(4'h2, 3'd1, 32'h2);
    wait_out(3'b111, n); chk("wdt_expiry", n, 21);
    csr_rd(4'h2, 3'd1, rd); chk("wdt_en_cleared", rd, 32'h0);
    csr_rd(4'h2, 3'd0, rd); chk("cause_wdt", rd, 32'h70000);
    wait_out(3'b000, n); chk("wdt_recover", n, 26);
    csr_wr(4'h2, 3'd1, 32'h2);
    for (int i = 0; i < 5; i++) begin
      repeat (9) tick();
      csr_wr(4'h2, 3'd3, 32'h0);
      chk("wdt_kicked_no_reset", {29'd0, rst_out}, 32'h0);
    end
    csr_wr(4'h2, 3'd1, 32'h0);
`else
    // Without the watchdog its registers and enable read 0 and never fire.
    csr_wr(4'h2, 3'd2, 32'd20);
    csr_rd(4'h2, 3'd2, rd); chk("nowdt_reload_0", rd, 32'h0);
    csr_wr(4'h2, 3'd1, 32'h2);
    csr_rd(4'h2, 3'd1, rd); chk("nowdt_ctrl_bit1_0", rd, 32'h0);
    repeat (30) tick();
    chk("nowdt_no_reset", {29'd0, rst_out}, 32'h0);
    csr_rd(4'h2, 3'd0, rd); chk("nowdt_cause", rd, 32'h60000);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
